// File: rtl/pipe_pkg.sv
// Shared encodings for the ID/EX operand stage: ALU control codes, ALUOp codes,
// R-type funct codes and the bit positions inside the 4-bit control bundle.
package pipe_pkg;

  localparam logic [3:0] ALUCTL_AND = 4'b0000;
  localparam logic [3:0] ALUCTL_OR  = 4'b0001;
  localparam logic [3:0] ALUCTL_ADD = 4'b0010;
  localparam logic [3:0] ALUCTL_SUB = 4'b0110;
  localparam logic [3:0] ALUCTL_SLT = 4'b0111;
  localparam logic [3:0] ALUCTL_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  // ctl = {reg_write, mem_read, mem_write, mem_to_reg}
  localparam int CTL_REG_WRITE  = 3;
  localparam int CTL_MEM_READ   = 2;
  localparam int CTL_MEM_WRITE  = 1;
  localparam int CTL_MEM_TO_REG = 0;

  typedef struct packed {
    logic       illegal;
    logic [3:0] alu_ctl;
  } alu_dec_t;

endpackage

// File: rtl/fwd_unit.sv
// Per-source bypass mux: EX/MEM result beats MEM/WB result beats the value
// read from the register file; register 0 is never bypassed.
module fwd_unit #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic [RAW-1:0]  src,
  input  logic [XLEN-1:0] reg_data,
  input  logic            exm_wr,
  input  logic [RAW-1:0]  exm_rd,
  input  logic [XLEN-1:0] exm_data,
  input  logic            wb_wr,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] fwd_data
);

  logic exm_hit_s;
  logic wb_hit_s;

  assign exm_hit_s = exm_wr && (exm_rd != {RAW{1'b0}}) && (exm_rd == src);
  assign wb_hit_s  = wb_wr  && (wb_rd  != {RAW{1'b0}}) && (wb_rd  == src);

  // Priority select of the freshest producer.
  always_comb begin
    fwd_data = reg_data;
    if (exm_hit_s) begin
      fwd_data = exm_data;
    end else if (wb_hit_s) begin
      fwd_data = wb_data;
    end else begin
      fwd_data = reg_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with ALU-control decode, load-use bubble insertion
// and operand bypassing feeding the ripple-carry ALU.
module id_ex_operand_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [RAW-1:0]  id_rs,
  input  logic [RAW-1:0]  id_rt,
  input  logic [RAW-1:0]  id_rd,
  input  logic [XLEN-1:0] id_rs_data,
  input  logic [XLEN-1:0] id_rt_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [5:0]      id_funct,
  input  logic [1:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic [3:0]      id_ctl,
  input  logic            stall,
  input  logic            flush,
  input  logic            exm_wr,
  input  logic            wb_wr,
  input  logic [RAW-1:0]  exm_rd,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] exm_data,
  input  logic [XLEN-1:0] wb_data,
  output logic            load_use_stall,
  output logic [3:0]      alu_ctl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RAW-1:0]  ex_rd,
  output logic [3:0]      ex_ctl,
  output logic            ex_valid,
  output logic            ex_illegal
);

  logic            valid_r;
  logic [3:0]      ctl_r;
  logic            illegal_r;
  logic [3:0]      alu_ctl_r;
  logic [RAW-1:0]  rs_r;
  logic [RAW-1:0]  rt_r;
  logic [RAW-1:0]  rd_r;
  logic [XLEN-1:0] rs_data_r;
  logic [XLEN-1:0] rt_data_r;
  logic [XLEN-1:0] imm_r;
  logic            alu_src_r;

  logic            load_use_s;
  alu_dec_t        dec_s;
  logic [XLEN-1:0] fwd_rs_s;
  logic [XLEN-1:0] fwd_rt_s;

  function automatic alu_dec_t alu_decode(input logic [1:0] op, input logic [5:0] funct);
    alu_dec_t d;
    d.illegal = 1'b0;
    d.alu_ctl = ALUCTL_ADD;
    case (op)
      ALUOP_ADD: d.alu_ctl = ALUCTL_ADD;
      ALUOP_SUB: d.alu_ctl = ALUCTL_SUB;
      ALUOP_ORI: d.alu_ctl = ALUCTL_OR;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: d.alu_ctl = ALUCTL_ADD;
          FUNCT_SUB: d.alu_ctl = ALUCTL_SUB;
          FUNCT_AND: d.alu_ctl = ALUCTL_AND;
          FUNCT_OR:  d.alu_ctl = ALUCTL_OR;
          FUNCT_SLT: d.alu_ctl = ALUCTL_SLT;
          FUNCT_NOR: d.alu_ctl = ALUCTL_NOR;
          default: begin
            d.alu_ctl = ALUCTL_ADD;
            d.illegal = 1'b1;
          end
        endcase
      end
      default: d.alu_ctl = ALUCTL_ADD;
    endcase
    return d;
  endfunction

  assign dec_s = alu_decode(id_alu_op, id_funct);

  assign load_use_s = valid_r && ctl_r[CTL_MEM_READ] && id_valid && (rd_r != {RAW{1'b0}})
                      && ((rd_r == id_rs) || (rd_r == id_rt));

  // Stage register; flush outranks stall, which outranks the load-use bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r   <= 1'b0;
      ctl_r     <= 4'b0000;
      illegal_r <= 1'b0;
      alu_ctl_r <= 4'b0000;
      rs_r      <= {RAW{1'b0}};
      rt_r      <= {RAW{1'b0}};
      rd_r      <= {RAW{1'b0}};
      rs_data_r <= {XLEN{1'b0}};
      rt_data_r <= {XLEN{1'b0}};
      imm_r     <= {XLEN{1'b0}};
      alu_src_r <= 1'b0;
    end else if (flush || (!stall && load_use_s)) begin
      valid_r   <= 1'b0;
      ctl_r     <= 4'b0000;
      illegal_r <= 1'b0;
    end else if (!stall) begin
      valid_r   <= id_valid;
      ctl_r     <= id_valid ? id_ctl : 4'b0000;
      illegal_r <= id_valid & dec_s.illegal;
      alu_ctl_r <= dec_s.alu_ctl;
      rs_r      <= id_rs;
      rt_r      <= id_rt;
      rd_r      <= id_rd;
      rs_data_r <= id_rs_data;
      rt_data_r <= id_rt_data;
      imm_r     <= id_imm;
      alu_src_r <= id_alu_src;
    end
  end

  fwd_unit #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs (
    .src(rs_r), .reg_data(rs_data_r),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_data(fwd_rs_s)
  );

  fwd_unit #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rt (
    .src(rt_r), .reg_data(rt_data_r),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_data(fwd_rt_s)
  );

  // Operand outputs are forced to zero while the EX slot is empty.
  always_comb begin
    alu_a         = {XLEN{1'b0}};
    alu_b         = {XLEN{1'b0}};
    ex_store_data = {XLEN{1'b0}};
    if (valid_r) begin
      alu_a         = fwd_rs_s;
      alu_b         = alu_src_r ? imm_r : fwd_rt_s;
      ex_store_data = fwd_rt_s;
    end else begin
      alu_a         = {XLEN{1'b0}};
      alu_b         = {XLEN{1'b0}};
      ex_store_data = {XLEN{1'b0}};
    end
  end

  assign load_use_stall = load_use_s;
  assign alu_ctl        = alu_ctl_r;
  assign ex_rd          = rd_r;
  assign ex_ctl         = ctl_r;
  assign ex_valid       = valid_r;
  assign ex_illegal     = illegal_r;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: expectations are queued as stimulus
// is driven and popped when the stage output is sampled.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [5:0]  id_funct;
  logic [1:0]  id_alu_op;
  logic        id_alu_src;
  logic [3:0]  id_ctl;
  logic        stall, flush;
  logic        exm_wr, wb_wr;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_data, wb_data;
  logic        load_use_stall;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_ctl;
  logic        ex_valid, ex_illegal;

  typedef struct {
    logic        valid;
    logic [3:0]  ctl;
    logic [3:0]  alu_ctl;
    logic        illegal;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic        lus;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_funct(id_funct), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_ctl(id_ctl),
    .stall(stall), .flush(flush),
    .exm_wr(exm_wr), .wb_wr(wb_wr), .exm_rd(exm_rd), .wb_rd(wb_rd),
    .exm_data(exm_data), .wb_data(wb_data),
    .load_use_stall(load_use_stall), .alu_ctl(alu_ctl),
    .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_ctl(ex_ctl), .ex_valid(ex_valid), .ex_illegal(ex_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                       input logic [5:0] fn, input logic [1:0] op, input logic src, input logic [3:0] ctl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_funct = fn; id_alu_op = op; id_alu_src = src; id_ctl = ctl;
  endtask

  task automatic clear_fwd();
    exm_wr = 1'b0; exm_rd = 5'd0; exm_data = 32'd0;
    wb_wr = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    clear_fwd();
    issue(1'b1, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 6'b100000, 2'b10, 1'b0, 4'b1000);
    sb.push_back('{valid:1'b0, ctl:4'b0000, alu_ctl:4'b0000, illegal:1'b0, rd:5'd0,
                   a:32'd0, b:32'd0, sd:32'd0, lus:1'b0});
    tick(); tick();
    e = sb.pop_front();
    total++; if (ex_valid !== e.valid) $display("FAIL reset_valid got=%0b exp=%0b", ex_valid, e.valid); else passed++;
    total++; if (ex_ctl !== e.ctl) $display("FAIL reset_ctl got=%b exp=%b", ex_ctl, e.ctl); else passed++;
    total++; if (alu_ctl !== e.alu_ctl) $display("FAIL reset_alu_ctl got=%b exp=%b", alu_ctl, e.alu_ctl); else passed++;
    total++; if (ex_illegal !== e.illegal) $display("FAIL reset_illegal got=%0b exp=%0b", ex_illegal, e.illegal); else passed++;
    total++; if (ex_rd !== e.rd) $display("FAIL reset_rd got=%0d exp=%0d", ex_rd, e.rd); else passed++;
    total++; if ({alu_a, alu_b, ex_store_data} !== {e.a, e.b, e.sd})
      $display("FAIL reset_operands got=%h/%h/%h exp=0", alu_a, alu_b, ex_store_data); else passed++;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_alu_decode();
    logic [5:0] fn_tab [10];
    logic [1:0] op_tab [10];
    logic [3:0] ctl_tab[10];
    logic       ill_tab[10];
    fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000,
                6'b000000, 6'b111111, 6'b000000};
    op_tab  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
    ctl_tab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100, 4'b0010, 4'b0010, 4'b0110, 4'b0001};
    ill_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      issue(1'b1, 5'd1, 5'd2, 5'd3, 32'h10, 32'h20, 32'h0, fn_tab[i], op_tab[i], 1'b0, 4'b1000);
      sb.push_back('{valid:1'b1, ctl:4'b1000, alu_ctl:ctl_tab[i], illegal:ill_tab[i], rd:5'd3,
                     a:32'h10, b:32'h20, sd:32'h20, lus:1'b0});
      tick();
      e = sb.pop_front();
      total++; if (alu_ctl !== e.alu_ctl)
        $display("FAIL decode_alu_ctl[%0d] got=%b exp=%b", i, alu_ctl, e.alu_ctl); else passed++;
      total++; if (ex_illegal !== e.illegal)
        $display("FAIL decode_illegal[%0d] got=%0b exp=%0b", i, ex_illegal, e.illegal); else passed++;
    end
    total++; if (alu_b !== e.b) $display("FAIL decode_alu_b got=%h exp=%h", alu_b, e.b); else passed++;
  endtask

  task automatic test_forwarding();
    issue(1'b1, 5'd5, 5'd6, 5'd9, 32'hAA, 32'hBB, 32'h0, 6'b100000, 2'b00, 1'b0, 4'b1000);
    sb.push_back('{valid:1'b1, ctl:4'b1000, alu_ctl:4'b0010, illegal:1'b0, rd:5'd9,
                   a:32'h11, b:32'hBB, sd:32'hBB, lus:1'b0});
    sb.push_back('{valid:1'b1, ctl:4'b1000, alu_ctl:4'b0010, illegal:1'b0, rd:5'd9,
                   a:32'h22, b:32'hBB, sd:32'hBB, lus:1'b0});
    sb.push_back('{valid:1'b1, ctl:4'b1000, alu_ctl:4'b0010, illegal:1'b0, rd:5'd9,
                   a:32'hAA, b:32'hBB, sd:32'hBB, lus:1'b0});
    tick();
    exm_wr = 1'b1; exm_rd = 5'd5; exm_data = 32'h11;
    wb_wr = 1'b1; wb_rd = 5'd5; wb_data = 32'h22;
    #1 e = sb.pop_front();
    total++; if (alu_a !== e.a) $display("FAIL fwd_exm_priority got=%h exp=%h", alu_a, e.a); else passed++;
    total++; if (alu_b !== e.b) $display("FAIL fwd_rt_untouched got=%h exp=%h", alu_b, e.b); else passed++;
    exm_wr = 1'b0;
    #1 e = sb.pop_front();
    total++; if (alu_a !== e.a) $display("FAIL fwd_wb got=%h exp=%h", alu_a, e.a); else passed++;
    wb_wr = 1'b0;
    #1 e = sb.pop_front();
    total++; if (alu_a !== e.a) $display("FAIL fwd_none got=%h exp=%h", alu_a, e.a); else passed++;
    clear_fwd();
    issue(1'b1, 5'd0, 5'd6, 5'd9, 32'h33, 32'hBB, 32'h0, 6'b100000, 2'b00, 1'b0, 4'b1000);
    sb.push_back('{valid:1'b1, ctl:4'b1000, alu_ctl:4'b0010, illegal:1'b0, rd:5'd9,
                   a:32'h33, b:32'hBB, sd:32'hBB, lus:1'b0});
    tick();
    exm_wr = 1'b1; exm_rd = 5'd0; exm_data = 32'h44;
    wb_wr = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
    #1 e = sb.pop_front();
    total++; if (alu_a !== e.a) $display("FAIL fwd_reg0 got=%h exp=%h", alu_a, e.a); else passed++;
    clear_fwd();
  endtask

  task automatic test_load_use();
    issue(1'b1, 5'd1, 5'd8, 5'd8, 32'h100, 32'h0, 32'h4, 6'b000000, 2'b00, 1'b1, 4'b1101);
    tick();
    issue(1'b1, 5'd8, 5'd9, 5'd10, 32'h7, 32'h8, 32'h0, 6'b100000, 2'b10, 1'b0, 4'b1000);
    sb.push_back('{valid:1'b1, ctl:4'b1101, alu_ctl:4'b0010, illegal:1'b0, rd:5'd8,
                   a:32'h100, b:32'h4, sd:32'h0, lus:1'b1});
    sb.push_back('{valid:1'b0, ctl:4'b0000, alu_ctl:4'b0010, illegal:1'b0, rd:5'd8,
                   a:32'h0, b:32'h0, sd:32'h0, lus:1'b0});
    sb.push_back('{valid:1'b1, ctl:4'b1000, alu_ctl:4'b0010, illegal:1'b0, rd:5'd10,
                   a:32'h7, b:32'h8, sd:32'h8, lus:1'b0});
    #1 e = sb.pop_front();
    total++; if (load_use_stall !== e.lus) $display("FAIL lu_detect got=%0b exp=%0b", load_use_stall, e.lus); else passed++;
    tick();
    e = sb.pop_front();
    total++; if (ex_valid !== e.valid) $display("FAIL lu_bubble_valid got=%0b exp=%0b", ex_valid, e.valid); else passed++;
    total++; if (ex_ctl !== e.ctl) $display("FAIL lu_bubble_ctl got=%b exp=%b", ex_ctl, e.ctl); else passed++;
    total++; if (load_use_stall !== e.lus) $display("FAIL lu_release got=%0b exp=%0b", load_use_stall, e.lus); else passed++;
    total++; if (alu_a !== e.a) $display("FAIL lu_bubble_a got=%h exp=%h", alu_a, e.a); else passed++;
    tick();
    e = sb.pop_front();
    total++; if ({ex_valid, ex_rd, ex_ctl} !== {e.valid, e.rd, e.ctl})
      $display("FAIL lu_capture got=%0b/%0d/%b exp=%0b/%0d/%b", ex_valid, ex_rd, ex_ctl, e.valid, e.rd, e.ctl);
    else passed++;
    total++; if (alu_a !== e.a) $display("FAIL lu_capture_a got=%h exp=%h", alu_a, e.a); else passed++;
  endtask

  task automatic test_flush_stall();
    issue(1'b1, 5'd2, 5'd4, 5'd3, 32'h20, 32'h21, 32'h0, 6'b100101, 2'b10, 1'b0, 4'b1000);
    sb.push_back('{valid:1'b1, ctl:4'b1000, alu_ctl:4'b0001, illegal:1'b0, rd:5'd3,
                   a:32'h20, b:32'h21, sd:32'h21, lus:1'b0});
    tick();
    issue(1'b1, 5'd6, 5'd7, 5'd4, 32'h40, 32'h41, 32'h0, 6'b100010, 2'b10, 1'b0, 4'b1001);
    stall = 1'b1;
    tick();
    e = sb.pop_front();
    total++; if ({ex_valid, ex_rd, ex_ctl, alu_ctl} !== {e.valid, e.rd, e.ctl, e.alu_ctl})
      $display("FAIL stall_hold got=%0b/%0d/%b/%b exp=%0b/%0d/%b/%b", ex_valid, ex_rd, ex_ctl, alu_ctl,
               e.valid, e.rd, e.ctl, e.alu_ctl);
    else passed++;
    total++; if ({alu_a, alu_b} !== {e.a, e.b}) $display("FAIL stall_operands got=%h/%h exp=%h/%h", alu_a, alu_b, e.a, e.b); else passed++;
    flush = 1'b1;
    sb.push_back('{valid:1'b0, ctl:4'b0000, alu_ctl:4'b0001, illegal:1'b0, rd:5'd3,
                   a:32'h0, b:32'h0, sd:32'h0, lus:1'b0});
    tick();
    e = sb.pop_front();
    total++; if ({ex_valid, ex_ctl} !== {e.valid, e.ctl})
      $display("FAIL flush_over_stall got=%0b/%b exp=%0b/%b", ex_valid, ex_ctl, e.valid, e.ctl); else passed++;
    flush = 1'b0; stall = 1'b0;
    issue(1'b0, 5'd6, 5'd7, 5'd4, 32'h40, 32'h41, 32'h0, 6'b000000, 2'b10, 1'b0, 4'b1111);
    sb.push_back('{valid:1'b0, ctl:4'b0000, alu_ctl:4'b0010, illegal:1'b0, rd:5'd4,
                   a:32'h0, b:32'h0, sd:32'h0, lus:1'b0});
    tick();
    e = sb.pop_front();
    total++; if ({ex_valid, ex_ctl, ex_illegal} !== {e.valid, e.ctl, e.illegal})
      $display("FAIL invalid_gating got=%0b/%b/%0b exp=%0b/%b/%0b", ex_valid, ex_ctl, ex_illegal,
               e.valid, e.ctl, e.illegal);
    else passed++;
  endtask

  task automatic test_imm_store();
    issue(1'b1, 5'd0, 5'd7, 5'd0, 32'h0, 32'h99, 32'hFFFF_FFFC, 6'b000000, 2'b00, 1'b1, 4'b0010);
    sb.push_back('{valid:1'b1, ctl:4'b0010, alu_ctl:4'b0010, illegal:1'b0, rd:5'd0,
                   a:32'h0, b:32'hFFFF_FFFC, sd:32'h55, lus:1'b0});
    tick();
    wb_wr = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
    #1 e = sb.pop_front();
    total++; if (alu_b !== e.b) $display("FAIL imm_alu_b got=%h exp=%h", alu_b, e.b); else passed++;
    total++; if (ex_store_data !== e.sd) $display("FAIL imm_store_data got=%h exp=%h", ex_store_data, e.sd); else passed++;
    clear_fwd();
  endtask

  task automatic test_async_reset();
    issue(1'b1, 5'd3, 5'd4, 5'd12, 32'h77, 32'h88, 32'h0, 6'b100100, 2'b10, 1'b0, 4'b1000);
    sb.push_back('{valid:1'b1, ctl:4'b1000, alu_ctl:4'b0000, illegal:1'b0, rd:5'd12,
                   a:32'h77, b:32'h88, sd:32'h88, lus:1'b0});
    sb.push_back('{valid:1'b0, ctl:4'b0000, alu_ctl:4'b0000, illegal:1'b0, rd:5'd0,
                   a:32'h0, b:32'h0, sd:32'h0, lus:1'b0});
    sb.push_back('{valid:1'b0, ctl:4'b0000, alu_ctl:4'b0000, illegal:1'b0, rd:5'd0,
                   a:32'h0, b:32'h0, sd:32'h0, lus:1'b0});
    sb.push_back('{valid:1'b1, ctl:4'b1000, alu_ctl:4'b0000, illegal:1'b0, rd:5'd12,
                   a:32'h77, b:32'h88, sd:32'h88, lus:1'b0});
    tick();
    e = sb.pop_front();
    total++; if ({ex_valid, ex_rd} !== {e.valid, e.rd}) $display("FAIL arst_pre got=%0b/%0d exp=%0b/%0d", ex_valid, ex_rd, e.valid, e.rd); else passed++;
    #2 rst_n = 1'b0;
    #1 e = sb.pop_front();
    total++; if ({ex_valid, ex_ctl, ex_rd, alu_a} !== {e.valid, e.ctl, e.rd, e.a})
      $display("FAIL arst_immediate got=%0b/%b/%0d/%h exp=%0b/%b/%0d/%h", ex_valid, ex_ctl, ex_rd, alu_a,
               e.valid, e.ctl, e.rd, e.a);
    else passed++;
    tick();
    e = sb.pop_front();
    total++; if ({ex_valid, ex_rd} !== {e.valid, e.rd}) $display("FAIL arst_held got=%0b/%0d exp=%0b/%0d", ex_valid, ex_rd, e.valid, e.rd); else passed++;
    #2 rst_n = 1'b1;
    tick();
    e = sb.pop_front();
    total++; if ({ex_valid, ex_rd, alu_a} !== {e.valid, e.rd, e.a})
      $display("FAIL arst_first_capture got=%0b/%0d/%h exp=%0b/%0d/%h", ex_valid, ex_rd, alu_a, e.valid, e.rd, e.a);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_alu_decode();
    test_forwarding();
    test_load_use();
    test_flush_stall();
    test_imm_store();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
